// File: rtl/game_pkg.sv
// Shared game types: top-level game state/mode, shot frame opcodes and the
// shot generator FSM states.
package game_pkg;

  typedef enum logic [1:0] {START, SHOOTER, KEEPER, SCORE} g_state;
  typedef enum logic {SOLO, MULTI} g_mode;

  // Opcodes in uart_data[7:5]; the shooter-side transmitter uses the same set.
  localparam logic [2:0] SHOT_X_HI = 3'b001;
  localparam logic [2:0] SHOT_X_LO = 3'b010;
  localparam logic [2:0] SHOT_Y_HI = 3'b011;
  localparam logic [2:0] SHOT_Y_LO = 3'b100;

  typedef enum logic [1:0] {SH_IDLE, SH_COLLECT, SH_COMMIT, SH_HOLD} shot_state;

  function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/shot_generator_lfsr.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11; free-running, never reaches zero.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  logic [15:0] r_value;
  logic        w_fb;

  assign w_fb  = r_value[0] ^ r_value[2] ^ r_value[3] ^ r_value[5];
  assign value = r_value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_value <= SEED;
    else      r_value <= {w_fb, r_value[15:1]};
  end

endmodule

// File: rtl/shot_generator.sv
// Shot target generator: random position in SOLO, UART-assembled position in
// MULTI; holds the position for the whole KEEPER round.
module shot_generator
  import game_pkg::*;
#(
  parameter int X_MIN = 150,
  parameter int Y_MIN = 250,
  parameter int X_LIM = 923,
  parameter int Y_LIM = 667
) (
  input  logic       clk,
  input  logic       rst,
  input  g_state     game_state,
  input  g_mode      game_mode,
  input  logic [7:0] uart_data,
  input  logic       uart_valid,
  output logic [9:0] shot_xpos,
  output logic [9:0] shot_ypos,
  output logic       shot_valid
);

  localparam logic [9:0] XMIN10 = 10'(X_MIN);
  localparam logic [9:0] YMIN10 = 10'(Y_MIN);
  localparam logic [9:0] XLIM10 = 10'(X_LIM);
  localparam logic [9:0] YLIM10 = 10'(Y_LIM);

  shot_state   r_state, w_state_nxt;
  logic        r_keeper_d;
  logic [3:0]  r_mask, w_mask_nxt, w_mask_upd;
  logic [9:0]  r_x, r_y, w_x_nxt, w_y_nxt, w_x_upd, w_y_upd;
  logic [9:0]  r_xpos, r_ypos, w_xpos_nxt, w_ypos_nxt;
  logic        r_valid, w_valid_nxt;
  logic [15:0] w_lfsr;
  logic        w_keeper, w_entry;

  lfsr16 #(.SEED(16'hACE1)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (w_lfsr)
  );

  assign w_keeper   = (game_state == KEEPER);
  assign w_entry    = w_keeper && !r_keeper_d;
  assign shot_xpos  = r_xpos;
  assign shot_ypos  = r_ypos;
  assign shot_valid = r_valid;

  // Frame decode; only consumed while collecting.
  always_comb begin
    w_mask_upd = r_mask;
    w_x_upd    = r_x;
    w_y_upd    = r_y;
    if (uart_valid) begin
      case (uart_data[7:5])
        SHOT_X_HI: begin w_x_upd[9:5] = uart_data[4:0]; w_mask_upd[0] = 1'b1; end
        SHOT_X_LO: begin w_x_upd[4:0] = uart_data[4:0]; w_mask_upd[1] = 1'b1; end
        SHOT_Y_HI: begin w_y_upd[9:5] = uart_data[4:0]; w_mask_upd[2] = 1'b1; end
        SHOT_Y_LO: begin w_y_upd[4:0] = uart_data[4:0]; w_mask_upd[3] = 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_xpos_nxt  = r_xpos;
    w_ypos_nxt  = r_ypos;
    w_valid_nxt = r_valid;
    case (r_state)
      SH_IDLE: begin
        if (w_entry) begin
          if (game_mode == SOLO) begin
            w_xpos_nxt  = XMIN10 + {1'b0, w_lfsr[8:0]};
            w_ypos_nxt  = YMIN10 + {3'b000, w_lfsr[15:9]};
            w_valid_nxt = 1'b1;
            w_state_nxt = SH_HOLD;
          end else begin
            w_mask_nxt  = 4'b0000;
            w_state_nxt = SH_COLLECT;
          end
        end
      end
      SH_COLLECT: begin
        // Leaving KEEPER beats a completing frame in the same cycle.
        if (!w_keeper) begin
          w_mask_nxt  = 4'b0000;
          w_state_nxt = SH_IDLE;
        end else begin
          w_mask_nxt = w_mask_upd;
          w_x_nxt    = w_x_upd;
          w_y_nxt    = w_y_upd;
          if (w_mask_upd == 4'b1111) w_state_nxt = SH_COMMIT;
        end
      end
      SH_COMMIT: begin
        w_xpos_nxt  = clamp10(r_x, XLIM10);
        w_ypos_nxt  = clamp10(r_y, YLIM10);
        w_valid_nxt = 1'b1;
        w_state_nxt = SH_HOLD;
      end
      SH_HOLD: begin
        if (!w_keeper) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = SH_IDLE;
        end
      end
      default: w_state_nxt = SH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= SH_IDLE;
      r_keeper_d <= 1'b0;
      r_mask     <= 4'b0000;
      r_x        <= '0;
      r_y        <= '0;
      r_xpos     <= XMIN10;
      r_ypos     <= YMIN10;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_keeper_d <= w_keeper;
      r_mask     <= w_mask_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_xpos     <= w_xpos_nxt;
      r_ypos     <= w_ypos_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

endmodule
